// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver, 8N1 LSB first, held valid/ack byte handshake,
//            one-cycle framing / overrun / parity fault pulses.
//            Define UART_RX_PARITY_EN to receive 8E1 (even parity bit).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int c_CW           = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
  // Last count of a full bit period, and the cycle of the mid-start-bit sample
  localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_IDLE   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_rx_s;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
`endif

  logic            w_bit_done;
  logic            w_half_done;
  logic [c_CW-1:0] w_cnt_next;

  assign w_bit_done  = (r_cnt == c_BIT_LAST);
  assign w_half_done = (r_cnt == c_HALF_LAST);
  assign w_cnt_next  = r_cnt + c_CNT_ONE;

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous line; idles high out of reset
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  // Receive FSM with registered byte handshake and fault pulses
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_state    <= S_HUNT;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Acknowledge clears the byte; an acceptance below in the same cycle wins
      if (data_ack) begin
        data_valid <= 1'b0;
      end

      case (r_state)
        // Wait for a full bit time of continuous idle before arming
        S_HUNT: begin
          if (!r_rx_s) begin
            r_cnt <= '0;
          end else if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            busy      <= 1'b1;
            r_state   <= S_START;
          end
        end

        // Re-check the start bit at its centre to reject short glitches
        S_START: begin
          if (w_half_done) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        S_DATA: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit must equal the XOR of the data bits
        S_PARITY: begin
          if (w_bit_done) begin
            r_cnt     <= '0;
            r_par_bad <= (r_rx_s != ^r_shift);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
`endif

        // Leave at mid-stop-bit so a back-to-back start edge is not missed
        S_STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            busy  <= 1'b0;
            if (!r_rx_s) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= r_par_bad;
`endif
              r_state   <= S_HUNT;
`ifdef UART_RX_PARITY_EN
            end else if (r_par_bad) begin
              parity_err <= 1'b1;
              r_state    <= S_IDLE;
`endif
            end else begin
              r_state <= S_IDLE;
              if (data_valid && !data_ack) begin
                overrun <= 1'b1;
              end else begin
                data       <= r_shift;
                data_valid <= 1'b1;
              end
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        default: begin
          r_cnt   <= '0;
          busy    <= 1'b0;
          r_state <= S_HUNT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx: directed frames from the test
//            plan plus randomised frames against a byte-level reference model.
//            Define UART_RX_PARITY_EN to exercise the 8E1 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int c_BIT = 25000000 / 115200;
`ifdef UART_RX_PARITY_EN
  localparam bit c_PAR = 1'b1;
  localparam int c_LAT = 2278;  // busy rise to busy fall / data_valid rise
  localparam int c_ACC = 2280;  // negedges from start-bit drive to stop sample cycle
`else
  localparam bit c_PAR = 1'b0;
  localparam int c_LAT = 2061;
  localparam int c_ACC = 2063;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx dut (
    .clk_25mhz  (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation counters built from DUT activity
  int cyc = 0;
  int busy_rise = 0, busy_fall = 0, dv_rise = 0, dv_fall_cnt = 0;
  int fe_cyc = 0, ov_cyc = 0, pe_cyc = 0;
  logic prev_busy = 1'b0, prev_dv = 1'b0;

  // Reference model state
  logic [7:0] md = 8'h00;
  logic       mv = 1'b0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge and pulse bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy === 1'b0) busy_rise <= cyc;
    if (busy === 1'b0 && prev_busy === 1'b1) busy_fall <= cyc;
    if (data_valid === 1'b1 && prev_dv === 1'b0) dv_rise <= cyc;
    if (data_valid === 1'b0 && prev_dv === 1'b1) dv_fall_cnt <= dv_fall_cnt + 1;
    if (frame_err === 1'b1)  fe_cyc <= fe_cyc + 1;
    if (overrun === 1'b1)    ov_cyc <= ov_cyc + 1;
    if (parity_err === 1'b1) pe_cyc <= pe_cyc + 1;
    prev_busy <= busy;
    prev_dv   <= data_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; optionally acknowledge in the stop-sample cycle
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pflip, input bit ack_acc);
    fork
      begin
        rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx = b[i];
          repeat (c_BIT) @(negedge clk);
        end
        if (c_PAR) begin
          rx = (^b) ^ pflip;
          repeat (c_BIT) @(negedge clk);
        end
        rx = stop_ok;
        repeat (c_BIT) @(negedge clk);
        rx = 1'b1;
      end
      begin
        if (ack_acc) begin
          repeat (c_ACC) @(negedge clk);
          data_ack = 1'b1;
          @(negedge clk);
          data_ack = 1'b0;
        end
      end
    join
  endtask

  // Send a frame to an armed receiver, advance the model, compare everything
  task automatic frame(input logic [7:0] b, input bit stop_ok, input bit pflip, input bit ack_acc);
    send_frame(b, stop_ok, pflip, ack_acc);
    if (!stop_ok) exp_fe++;
    if (pflip) exp_pe++;
    if (stop_ok && !pflip) begin
      if (mv && !ack_acc) exp_ov++;
      else begin
        md = b;
        mv = 1'b1;
      end
    end else if (ack_acc) begin
      mv = 1'b0;
    end
    check("busy_len", busy_fall - busy_rise, c_LAT);
    check("data", {24'd0, data}, {24'd0, md});
    check("valid", {31'd0, data_valid}, {31'd0, mv});
    check("frame_err_cycles", fe_cyc, exp_fe);
    check("overrun_cycles", ov_cyc, exp_ov);
    check("parity_err_cycles", pe_cyc, exp_pe);
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    mv = 1'b0;
    check("ack_clears_valid", {31'd0, data_valid}, 32'd0);
  endtask

  initial begin
    int snap;
    logic [7:0] rb;

    rx = 1'b1;
    data_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    reset = 1'b0;
    idle(c_BIT);

    // Basic reception, valid rises together with busy falling
    frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("valid_with_busy_fall", dv_rise, busy_fall);
    ack_pulse();
    idle(40);

    // Short low glitch: start re-check rejects it
    rx = 1'b0;
    repeat (50) @(negedge clk);
    idle(200);
    check("glitch_busy_len", busy_fall - busy_rise, c_BIT / 2);
    check("glitch_valid", {31'd0, data_valid}, {31'd0, mv});
    check("glitch_fe", fe_cyc, exp_fe);
    check("glitch_ov", ov_cyc, exp_ov);

    // Framing error, then a frame arriving before a full idle bit is ignored
    frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    check("hunt_ignores_valid", {31'd0, data_valid}, 32'd0);
    check("hunt_ignores_data", {24'd0, data}, {24'd0, md});
    check("hunt_ignores_fe", fe_cyc, exp_fe);
    idle(20);

    // Overrun without ack, then ack landing in the accept cycle
    frame(8'h11, 1'b1, 1'b0, 1'b0);
    frame(8'h22, 1'b1, 1'b0, 1'b0);
    ack_pulse();
    frame(8'h11, 1'b1, 1'b0, 1'b0);
    snap = dv_fall_cnt;
    frame(8'h22, 1'b1, 1'b0, 1'b1);
    check("ack_accept_no_drop", dv_fall_cnt, snap);
    idle(30);

    // Reset in the middle of D4; upper data bits low so no idle run follows
    rb = 8'($urandom) & 8'h0F;
    fork
      send_frame(rb, 1'b1, 1'b0, 1'b0);
      begin
        repeat (c_BIT * 5 + 100) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_data", {24'd0, data}, 32'd0);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    md = 8'h00;
    mv = 1'b0;
    check("midrst_no_valid_after", {31'd0, data_valid}, 32'd0);
    check("midrst_no_fe", fe_cyc, exp_fe);
    idle(30);
    frame(8'h5A, 1'b1, 1'b0, 1'b0);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0, 1'b0);
    ack_pulse();
    frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(30);
`endif

    // Randomised frames, acks and gaps against the model
    for (int k = 0; k < 14; k++) begin
      logic [7:0] b;
      bit st, pf, aa;
      int pol, gap;
      b   = 8'($urandom);
      st  = ($urandom_range(0, 5) != 0);
      pf  = c_PAR && ($urandom_range(0, 4) == 0);
      pol = $urandom_range(0, 2);
      aa  = (pol == 1);
      frame(b, st, pf, aa);
      if (pol == 2) ack_pulse();
      if (st) gap = $urandom_range(0, 1) * $urandom_range(1, 300);
      else    gap = 250 + $urandom_range(0, 100);
      if (gap > 0) idle(gap);
    end

    check("final_fe", fe_cyc, exp_fe);
    check("final_ov", ov_cyc, exp_ov);
    check("final_pe", pe_cyc, exp_pe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
